// File: rtl/irq_timer_tick.sv
// irq_timer_tick: shared prescaler plus M_TARGETS programmable down-count
// channels, each one-shot or periodic, producing registered one-cycle
// timer_tick pulses for the interrupt controller. Registers are reached
// through a simple single-cycle synchronous read/write port.
module irq_timer_tick #(
    parameter int M_TARGETS = 1,
    parameter int CNT_W     = 32,
    parameter int PRESC_W   = 16,
    localparam int TGT_W    = (M_TARGETS > 1) ? $clog2(M_TARGETS) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 reg_wr_en,
    input  logic                 reg_rd_en,
    input  logic [TGT_W-1:0]     reg_target,
    input  logic [1:0]           reg_addr,
    input  logic [31:0]          reg_wdata,
    output logic [31:0]          reg_rdata,
    output logic                 reg_rvalid,
    output logic                 reg_err,
    output logic [M_TARGETS-1:0] timer_tick
);

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_PERIOD = 2'd1;
    localparam logic [1:0] ADDR_COUNT  = 2'd2;
    localparam logic [1:0] ADDR_PRESC  = 2'd3;

    // One extra bit so M_TARGETS == 2**TGT_W is still representable.
    localparam logic [TGT_W:0] TGT_LIMIT = (TGT_W + 1)'(M_TARGETS);

    logic tgt_valid;
    logic chan_access;
    logic presc_wr;

    assign tgt_valid   = ({1'b0, reg_target} < TGT_LIMIT);
    assign chan_access = (reg_addr != ADDR_PRESC);
    assign presc_wr    = reg_wr_en && (reg_addr == ADDR_PRESC);

    // ------------------------------------------------------------------
    // Shared prescaler
    // ------------------------------------------------------------------
    logic [PRESC_W-1:0] presc_q_reg;
    logic [PRESC_W-1:0] presc_cnt_reg;
    logic               tick_en;

    // A PRESC write restarts the prescaler and suppresses that cycle's tick.
    assign tick_en = (presc_cnt_reg == presc_q_reg) && !presc_wr;

    // Prescaler reload value and free-running 0..presc_q counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q_reg   <= '0;
            presc_cnt_reg <= '0;
        end else if (presc_wr) begin
            presc_q_reg   <= reg_wdata[PRESC_W-1:0];
            presc_cnt_reg <= '0;
        end else if (presc_cnt_reg == presc_q_reg) begin
            presc_cnt_reg <= '0;
        end else begin
            presc_cnt_reg <= presc_cnt_reg + PRESC_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Channels
    // ------------------------------------------------------------------
    logic [31:0] ctrl_val   [M_TARGETS];
    logic [31:0] period_val [M_TARGETS];
    logic [31:0] count_val  [M_TARGETS];

    for (genvar gi = 0; gi < M_TARGETS; gi++) begin : g_chan
        logic             en_reg;
        logic             periodic_reg;
        logic             fired_reg;
        logic             tick_reg;
        logic [CNT_W-1:0] period_reg;
        logic [CNT_W-1:0] count_reg;
        logic             sel;
        logic             wr_ctrl;
        logic             wr_period;
        logic             wr_count;
        logic             count_hold;

        assign sel       = tgt_valid && (reg_target == TGT_W'(gi));
        assign wr_ctrl   = reg_wr_en && sel && (reg_addr == ADDR_CTRL);
        assign wr_period = reg_wr_en && sel && (reg_addr == ADDR_PERIOD);
        assign wr_count  = reg_wr_en && sel && (reg_addr == ADDR_COUNT);

        // Writes that touch the count path (PERIOD, COUNT, or a CTRL write
        // that toggles EN) take precedence over the countdown this cycle.
        // A CTRL write that keeps EN at 1 leaves the countdown alone, so a
        // FIRE coinciding with a FIRED write-1-clear still fires and wins.
        assign count_hold = wr_period || wr_count ||
                            (wr_ctrl && (reg_wdata[0] != en_reg));

        // Channel state: register writes, enable reload, countdown and fire.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                en_reg       <= 1'b0;
                periodic_reg <= 1'b0;
                fired_reg    <= 1'b0;
                tick_reg     <= 1'b0;
                period_reg   <= '0;
                count_reg    <= '0;
            end else begin
                tick_reg <= 1'b0;
                if (wr_ctrl) begin
                    en_reg       <= reg_wdata[0];
                    periodic_reg <= reg_wdata[1];
                    if (reg_wdata[2]) begin
                        fired_reg <= 1'b0;
                    end
                    if (!en_reg && reg_wdata[0]) begin
                        count_reg <= period_reg;
                    end
                end
                if (wr_period) begin
                    period_reg <= reg_wdata[CNT_W-1:0];
                end
                if (wr_count) begin
                    count_reg <= reg_wdata[CNT_W-1:0];
                end
                if (tick_en && en_reg && !count_hold) begin
                    if (count_reg == '0) begin
                        tick_reg  <= 1'b1;
                        fired_reg <= 1'b1;
                        if (periodic_reg) begin
                            count_reg <= period_reg;
                        end else begin
                            en_reg <= 1'b0;
                        end
                    end else begin
                        count_reg <= count_reg - CNT_W'(1);
                    end
                end
            end
        end

        assign timer_tick[gi] = tick_reg;
        assign ctrl_val[gi]   = {29'd0, fired_reg, periodic_reg, en_reg};
        assign period_val[gi] = 32'(period_reg);
        assign count_val[gi]  = 32'(count_reg);
    end

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    logic [31:0] rd_value;

    // Select the addressed register; invalid targets read as zero.
    always_comb begin
        rd_value = '0;
        if (reg_addr == ADDR_PRESC) begin
            rd_value = 32'(presc_q_reg);
        end else begin
            for (int i = 0; i < M_TARGETS; i++) begin
                if (tgt_valid && (reg_target == TGT_W'(i))) begin
                    case (reg_addr)
                        ADDR_CTRL:   rd_value = ctrl_val[i];
                        ADDR_PERIOD: rd_value = period_val[i];
                        ADDR_COUNT:  rd_value = count_val[i];
                        default:     rd_value = '0;
                    endcase
                end
            end
        end
    end

    // Registered read response and error pulse (pre-write values on reads).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_rdata  <= '0;
            reg_rvalid <= 1'b0;
            reg_err    <= 1'b0;
        end else begin
            reg_rvalid <= reg_rd_en;
            reg_err    <= (reg_rd_en || reg_wr_en) && chan_access && !tgt_valid;
            if (reg_rd_en) begin
                reg_rdata <= rd_value;
            end
        end
    end

endmodule

// File: tb/tb_irq_timer_tick.sv
// Directed testbench for irq_timer_tick with three channels (target 3 invalid).
module tb_irq_timer_tick;

    logic        clk;
    logic        rst_n;
    logic        reg_wr_en;
    logic        reg_rd_en;
    logic [1:0]  reg_target;
    logic [1:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic [31:0] reg_rdata;
    logic        reg_rvalid;
    logic        reg_err;
    logic [2:0]  timer_tick;

    int checks = 0;
    int errors = 0;

    irq_timer_tick #(
        .M_TARGETS (3),
        .CNT_W     (32),
        .PRESC_W   (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .reg_wr_en  (reg_wr_en),
        .reg_rd_en  (reg_rd_en),
        .reg_target (reg_target),
        .reg_addr   (reg_addr),
        .reg_wdata  (reg_wdata),
        .reg_rdata  (reg_rdata),
        .reg_rvalid (reg_rvalid),
        .reg_err    (reg_err),
        .timer_tick (timer_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] tgt, input logic [1:0] addr, input logic [31:0] data);
        reg_wr_en  = 1'b1;
        reg_target = tgt;
        reg_addr   = addr;
        reg_wdata  = data;
        step();
        reg_wr_en  = 1'b0;
        $display("wr  tgt=%0d addr=%0d data=0x%08h", tgt, addr, data);
    endtask

    task automatic rd_check(input logic [1:0] tgt, input logic [1:0] addr,
                            input logic [31:0] exp_data, input logic exp_err, input string tag);
        reg_rd_en  = 1'b1;
        reg_target = tgt;
        reg_addr   = addr;
        step();
        reg_rd_en  = 1'b0;
        $display("rd  tgt=%0d addr=%0d data=0x%08h err=%0b", tgt, addr, reg_rdata, reg_err);
        check({tag, "_rvalid"}, 32'(reg_rvalid), 32'h1);
        check({tag, "_err"}, 32'(reg_err), 32'(exp_err));
        check({tag, "_data"}, reg_rdata, exp_data);
    endtask

    // Advance n edges; channel 0 must pulse exactly at edge fire_k (0 = never).
    task automatic wait_fire(input int n, input int fire_k, input string tag);
        for (int k = 1; k <= n; k++) begin
            step();
            check($sformatf("%s_k%0d", tag, k), 32'(timer_tick), (k == fire_k) ? 32'h1 : 32'h0);
        end
        $display("run %s: %0d cycles, pulse expected at %0d", tag, n, fire_k);
    endtask

    initial begin
        int n;
        rst_n      = 1'b0;
        reg_wr_en  = 1'b0;
        reg_rd_en  = 1'b0;
        reg_target = 2'd0;
        reg_addr   = 2'd0;
        reg_wdata  = 32'd0;

        // Reset state
        repeat (2) step();
        check("rst_tick", 32'(timer_tick), 32'h0);
        check("rst_rvalid", 32'(reg_rvalid), 32'h0);
        check("rst_err", 32'(reg_err), 32'h0);
        check("rst_rdata", reg_rdata, 32'h0);
        rst_n = 1'b1;
        step();

        // 1: PRESC=0, PERIOD=3, periodic -> pulses at W+4, W+8, W+12
        wr(2'd0, 2'd3, 32'd0);
        wr(2'd0, 2'd1, 32'd3);
        wr(2'd0, 2'd0, 32'h3);
        wait_fire(4, 4, "t1_a");
        wait_fire(4, 4, "t1_b");
        wait_fire(4, 4, "t1_c");
        wr(2'd0, 2'd0, 32'h4);            // disable (freeze count) and clear FIRED
        rd_check(2'd0, 2'd0, 32'h0, 1'b0, "t1_ctrl");
        rd_check(2'd0, 2'd2, 32'd3, 1'b0, "t1_count_frozen");

        // 2: PRESC=1, PERIOD=0, one-shot -> single pulse 2 clocks after enable
        wr(2'd0, 2'd1, 32'd0);
        wr(2'd0, 2'd3, 32'd1);
        step();
        wr(2'd0, 2'd0, 32'h1);
        wait_fire(6, 2, "t2");
        rd_check(2'd0, 2'd0, 32'h4, 1'b0, "t2_ctrl");
        rd_check(2'd0, 2'd2, 32'd0, 1'b0, "t2_count");

        // 3: PRESC=4, PERIOD=2 periodic; PRESC rewrite restarts the prescaler
        wr(2'd0, 2'd0, 32'h4);
        wr(2'd0, 2'd3, 32'd4);
        wr(2'd0, 2'd1, 32'd2);
        wr(2'd0, 2'd0, 32'h3);
        wait_fire(13, 13, "t3_a");
        wr(2'd0, 2'd3, 32'd4);
        wait_fire(15, 15, "t3_b");

        // 4: FIRED write-1-clear in the FIRE cycle -> FIRE wins
        wait_fire(14, 0, "t4_gap");
        wr(2'd0, 2'd0, 32'h7);
        check("t4_fire_with_clear", 32'(timer_tick), 32'h1);
        rd_check(2'd0, 2'd0, 32'h7, 1'b0, "t4_ctrl_fired");
        wr(2'd0, 2'd0, 32'h7);
        check("t4_no_fire", 32'(timer_tick), 32'h0);
        rd_check(2'd0, 2'd0, 32'h3, 1'b0, "t4_ctrl_cleared");

        // 5: invalid target 3
        wr(2'd3, 2'd1, 32'h55);
        check("t5_wr_err", 32'(reg_err), 32'h1);
        check("t5_wr_rvalid", 32'(reg_rvalid), 32'h0);
        rd_check(2'd3, 2'd1, 32'h0, 1'b1, "t5_rd_bad");
        step();
        check("t5_err_pulse_end", 32'(reg_err), 32'h0);
        rd_check(2'd0, 2'd1, 32'd2, 1'b0, "t5_ch0_period");
        rd_check(2'd1, 2'd1, 32'd0, 1'b0, "t5_ch1_period");
        rd_check(2'd3, 2'd3, 32'd4, 1'b0, "t5_presc_any_tgt");

        // Read and write in the same cycle returns the pre-write value
        reg_wr_en  = 1'b1;
        reg_wdata  = 32'h1234;
        rd_check(2'd1, 2'd1, 32'd0, 1'b0, "rw_same_cycle");
        reg_wr_en  = 1'b0;
        rd_check(2'd1, 2'd1, 32'h1234, 1'b0, "rw_after");

        // 6: asynchronous reset while a pulse is high
        n = 0;
        while (timer_tick[0] !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        check("t6_sync", 32'(timer_tick), 32'h1);
        #1 rst_n = 1'b0;
        #1;
        check("t6_async_tick", 32'(timer_tick), 32'h0);
        check("t6_async_rvalid", 32'(reg_rvalid), 32'h0);
        check("t6_async_rdata", reg_rdata, 32'h0);
        step();
        rst_n = 1'b1;
        rd_check(2'd0, 2'd0, 32'h0, 1'b0, "t6_ctrl");
        rd_check(2'd0, 2'd1, 32'h0, 1'b0, "t6_period");
        rd_check(2'd0, 2'd2, 32'h0, 1'b0, "t6_count");
        rd_check(2'd0, 2'd3, 32'h0, 1'b0, "t6_presc");
        rd_check(2'd1, 2'd1, 32'h0, 1'b0, "t6_ch1_period");
        wait_fire(30, 0, "t6_quiet");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule
